dict_decode: RTL and testbench
==============================

DICT_DECODE -- requirements
Module: dict_decode

Interface
REQ-001 SHALL have parameter HIST_AW, default 8, meaning history address width (history depth 2^HIST_AW = 256 bytes).
REQ-002 SHALL have parameter MAX_LEN, default 4, meaning maximum match length in bytes (token_len is a 2-bit field).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port token_valid  input  1  a token is presented.
REQ-006 SHALL have port token_ready  output  1  the block accepts a token this cycle.
REQ-007 SHALL have port token_is_match  input  1  0 = literal token, 1 = match token.
REQ-008 SHALL have port token_data  input  8  literal byte, or match offset minus 1 (offset 1..256).
REQ-009 SHALL have port token_len  input  2  match length minus 1 (length 1..4); ignored for literals.
REQ-010 SHALL have port out_valid  output  1  out_data holds a decoded byte.
REQ-011 SHALL have port out_ready  input  1  the downstream consumer takes out_data this cycle.
REQ-012 SHALL have port out_data  output  8  decoded byte.
REQ-013 SHALL have port busy  output  1  high while a match copy is in progress.

Function
REQ-014 SHALL implement states IDLE and COPY; busy = (state == COPY).
REQ-015 SHALL transfer a token only on token_valid && token_ready, and a byte only on out_valid && out_ready.
REQ-016 SHALL drive token_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-017 SHALL define "slot free" as (!out_valid || out_ready); out_data and out_valid SHALL hold while out_valid && !out_ready.
REQ-018 SHALL maintain a 256x8 history array hist and an 8-bit write pointer wr_ptr; every emitted byte is written to hist[wr_ptr] and wr_ptr increments mod 256 in the same cycle the byte is registered into out_data.
REQ-019 On acceptance of a literal in cycle N, SHALL register out_data = token_data and out_valid = 1 at the edge ending N (visible in N+1), write it to history, and remain in IDLE.
REQ-020 On acceptance of a match in cycle N, SHALL latch src_ptr = (wr_ptr - (token_data + 1)) mod 256 and remaining = token_len, go to COPY, and emit no byte in that cycle.
REQ-021 In COPY with slot free, SHALL register out_data = hist[src_ptr], set out_valid = 1, write the byte to hist[wr_ptr], and increment src_ptr and wr_ptr mod 256.
REQ-022 In COPY with slot free, SHALL return to IDLE if remaining == 0, else decrement remaining.
REQ-023 In COPY without a free slot, SHALL stall with no pointer, history, or counter change.
REQ-024 SHALL make the first match byte visible on out_data in cycle N+2 and later bytes one per cycle when out_ready stays high.
REQ-025 SHALL support overlapping copies (offset < length); a byte written in one cycle SHALL be readable by src_ptr in the next cycle, e.g. offset 1 repeats the last byte.
REQ-026 SHALL read 0x00 for history locations not written since reset.
REQ-027 SHALL clear out_valid when out_ready && out_valid and no new byte is registered that cycle.
REQ-028 An offset of 256 (token_data = 0xFF) SHALL read the byte written 256 emissions earlier; all pointer arithmetic SHALL be modulo 256.

Reset
REQ-029 On reset SHALL set state = IDLE, out_valid = 0, out_data = 0x00, busy = 0, wr_ptr = 0, src_ptr = 0, remaining = 0, and all hist entries = 0x00.
REQ-030 Reset during COPY SHALL abort the copy with no further bytes emitted, and reset SHALL override any simultaneous token or output transfer.
REQ-031 token_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Reset released -> out_valid = 0, busy = 0, token_ready = 1; match offset 1 length 2 as first token -> outputs 0x00, 0x00.
REQ-033 Literals 0x41, 0x42, 0x43 with out_ready = 1 -> out_data 0x41, 0x42, 0x43, each one cycle after acceptance.
REQ-034 After REQ-033, match token_data = 0x02, token_len = 3 -> outputs 0x41 0x42 0x43 0x41; token_ready low until the last byte is registered; busy high for 4 cycles.
REQ-035 Literal 0x5A, then match offset 1 length 4 -> outputs 0x5A 0x5A 0x5A 0x5A 0x5A.
REQ-036 During the REQ-034 copy, out_ready low for 3 cycles after the second byte -> out_data holds 0x42; the sequence resumes with no loss or duplication.
REQ-037 258 literals of value i mod 256 (i = 0..257), then match token_data = 0xFF, token_len = 1 -> outputs 0x02, 0x03; separately, reset asserted mid-copy -> out_valid = 0 on the next cycle and no further bytes.

Source files
------------

// File: rtl/dict_decode.sv
// Dictionary (LZ-style) token decoder: literals pass through, match tokens
// replay up to MAX_LEN bytes from a 2^HIST_AW-byte history of emitted output.
module dict_decode #(
    parameter int HIST_AW = 8,
    parameter int MAX_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       token_valid,
    output logic       token_ready,
    input  logic       token_is_match,
    input  logic [7:0] token_data,
    input  logic [1:0] token_len,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    localparam int DEPTH = 1 << HIST_AW;
    localparam int LW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [HIST_AW-1:0] src_ptr_q, src_ptr_d;
    logic [LW-1:0]      rem_q, rem_d;
    logic [7:0]         hist_q [DEPTH];

    logic       slot_free;
    logic       accept;
    logic       emit;
    logic [7:0] emit_byte;

    assign slot_free   = !out_valid_q || out_ready;
    assign token_ready = (state_q == IDLE) && slot_free;
    assign accept      = token_valid && token_ready;
    assign busy        = (state_q == COPY);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        rem_d     = rem_q;
        emit      = 1'b0;
        emit_byte = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (token_is_match) begin
                        // offset = token_data + 1, so source = wr - data - 1
                        src_ptr_d = wr_ptr_q - HIST_AW'(token_data)
                                  - HIST_AW'(1);
                        rem_d     = LW'(token_len);
                        state_d   = COPY;
                    end else begin
                        emit      = 1'b1;
                        emit_byte = token_data;
                    end
                end
            end
            COPY: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_byte = hist_q[src_ptr_q];
                    src_ptr_d = src_ptr_q + HIST_AW'(1);
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = emit || (out_valid_q && !out_ready);
        out_data_d  = emit ? emit_byte : out_data_q;
        wr_ptr_d    = emit ? wr_ptr_q + HIST_AW'(1) : wr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            wr_ptr_q    <= '0;
            src_ptr_q   <= '0;
            rem_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            src_ptr_q   <= src_ptr_d;
            rem_q       <= rem_d;
            if (emit) begin
                hist_q[wr_ptr_q] <= emit_byte;
            end
        end
    end

endmodule

// File: tb/tb_dict_decode.sv
// Scoreboard bench for dict_decode: a reference history model predicts every
// emitted byte; handshake timing and stall/reset behaviour checked directly.
module tb_dict_decode;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       token_valid = 1'b0;
    logic       token_ready;
    logic       token_is_match = 1'b0;
    logic [7:0] token_data = 8'h00;
    logic [1:0] token_len = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] exp_q [$];
    logic [7:0] mhist [256];
    logic [7:0] mwr = 8'h00;

    always #5 clk = ~clk;

    dict_decode dut (
        .clk           (clk),
        .reset         (reset),
        .token_valid   (token_valid),
        .token_ready   (token_ready),
        .token_is_match(token_is_match),
        .token_data    (token_data),
        .token_len     (token_len),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_byte", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("out_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic model_emit(input logic [7:0] b);
        mhist[mwr] = b;
        mwr = mwr + 8'd1;
        exp_q.push_back(b);
    endtask

    task automatic model_token(input bit m, input logic [7:0] d,
                               input logic [1:0] l);
        logic [7:0] src;
        if (!m) begin
            model_emit(d);
        end else begin
            src = mwr - d - 8'd1;
            for (int k = 0; k <= int'(l); k++) begin
                model_emit(mhist[src]);
                src = src + 8'd1;
            end
        end
    endtask

    // Returns at posedge+1 of the cycle following acceptance.
    task automatic send(input bit m, input logic [7:0] d,
                        input logic [1:0] l);
        int n;
        n = 0;
        model_token(m, d, l);
        token_valid = 1'b1;
        token_is_match = m;
        token_data = d;
        token_len = l;
        do begin
            @(negedge clk);
            n++;
        end while (!token_ready && n < 200);
        if (!token_ready) begin
            chk("token_accept_timeout", {31'd0, token_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        token_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        token_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mhist[i] = 8'h00;
        mwr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        int cnt;
        int bad;
        bit found;

        for (int i = 0; i < 256; i++) mhist[i] = 8'h00;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_token_ready", {31'd0, token_ready}, 32'd1);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;

        // match into unwritten history reads zeros
        send(1'b1, 8'h00, 2'd1);
        drain();

        foreach (exp_q[i]) ;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'h41 + 8'(i);
            send(1'b0, b, 2'd0);
            chk("lit_lat_valid", {31'd0, out_valid}, 32'd1);
            chk("lit_lat_data", {24'd0, out_data}, {24'd0, b});
        end
        drain();

        send(1'b1, 8'h02, 2'd3);
        chk("match_gap", {31'd0, out_valid}, 32'd0);
        cnt = 0;
        bad = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (token_ready) bad++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", cnt, 32'd4);
        chk("ready_while_busy", bad, 32'd0);
        drain();

        send(1'b0, 8'h5A, 2'd0);
        send(1'b1, 8'h00, 2'd3);
        drain();

        // stall after the second copied byte
        do_reset();
        send(1'b0, 8'h41, 2'd0);
        send(1'b0, 8'h42, 2'd0);
        send(1'b0, 8'h43, 2'd0);
        drain();
        send(1'b1, 8'h02, 2'd3);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid && out_data == 8'h42) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("stall_seen", {31'd0, found}, 32'd1);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", {24'd0, out_data}, 32'h42);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // offset 256 after history wraps
        do_reset();
        for (int i = 0; i < 258; i++) begin
            send(1'b0, 8'(i), 2'd0);
        end
        send(1'b1, 8'hFF, 2'd1);
        drain();

        // reset in the middle of a copy
        do_reset();
        send(1'b0, 8'h77, 2'd0);
        drain();
        send(1'b1, 8'h00, 2'd3);
        @(posedge clk);
        #1;
        chk("midcopy_first", {24'd0, out_data}, 32'h77);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midcopy_valid", {31'd0, out_valid}, 32'd0);
        chk("midcopy_busy", {31'd0, busy}, 32'd0);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("midcopy_no_bytes", bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
